turtle_uart_rx: RTL
===================

// Module: turtle_uart_rx
// PURPOSE
// - 8N1 UART receiver for the Basys3 wrapper's RsRx pin; receive half of the link whose transmit half drives RsTx.
// - Oversamples the asynchronous serial line and reassembles bytes.
// - Presents each byte to the CPU-side logic over a one-entry valid/ready holding register.
// - Flags framing errors and overruns.
// PARAMETERS
// CLK_FREQ_HZ  62_500_000  frequency of clk_in as seen by this block (internal 16 ns clock)
// BAUD_RATE    115_200     serial bit rate
// OVERSAMPLE   16          ticks per bit; even, >= 8
// DATA_BITS    8           payload bits per frame, LSB first
// PORTS
// clk_in       in   1          system clock, all logic on rising edge
// reset_n      in   1          synchronous active-low reset
// rx_serial    in   1          raw RsRx line, asynchronous, idle high
// rx_data      out  DATA_BITS  received byte, stable while rx_valid=1
// rx_valid     out  1          holding register full
// rx_ready     in   1          consumer accepts; handshake completes when rx_valid && rx_ready at posedge
// frame_err    out  1          1-cycle pulse: stop bit sampled low
// overrun_err  out  1          1-cycle pulse: byte completed while holding register full and not draining
// busy         out  1          1 while state != IDLE
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): state=IDLE; rx_data=0; rx_valid=0; frame_err=0; overrun_err=0; busy=0.
//   Synchronizer flops=1, counters=0. Reset mid-frame discards the partial byte.
// - Synchronizer: 2-FF chain on rx_serial; all decisions use its output rx_s (2-cycle input latency).
// - Tick: DIV = round(CLK_FREQ_HZ/(BAUD_RATE*OVERSAMPLE)); 1-cycle tick every DIV clocks.
//   DIV < 1 is an elaboration error. Tick counter restarts to 0 on IDLE->START.
// - FSM (counters advance on tick only):
//   IDLE: rx_s==0 -> START, os_cnt=0.
//   START: at os_cnt==OVERSAMPLE/2-1, resample.
//     rx_s==1 -> IDLE (glitch, no error).
//     rx_s==0 -> DATA, os_cnt=0, bit_cnt=0.
//   DATA: at os_cnt==OVERSAMPLE-1, shift rx_s into shreg MSB (LSB-first frame); bit_cnt++.
//     After DATA_BITS samples -> STOP.
//   STOP: at os_cnt==OVERSAMPLE-1 (mid stop bit), sample.
//     rx_s==1 -> deliver, go IDLE.
//     rx_s==0 -> frame_err pulse, byte discarded, go WAIT_HIGH.
//   WAIT_HIGH: stay until rx_s==1 (break/line-low protection), then IDLE.
// - Deliver (clock after the stop-bit sample):
//   rx_valid==0, or rx_valid && rx_ready same cycle -> rx_data<=shreg, rx_valid<=1.
//   rx_valid && !rx_ready -> old byte kept, new byte dropped, overrun_err pulse.
// - rx_valid && rx_ready with no delivery -> rx_valid<=0 next cycle; rx_data holds last value.
// - frame_err and overrun_err never both asserted on the same cycle.
// - Back-to-back frames: IDLE re-arms in the cycle after stop sample; next start edge may be detected immediately.
// - Latency: start-edge at pin -> rx_valid high is approximately (1+DATA_BITS+0.5) bit times + 3 clk.
// STRUCTURE
// - turtle_uart_pkg:
//   - typedef enum logic [2:0] uart_rx_state_t {IDLE,START,DATA,STOP,WAIT_HIGH}
//   - function automatic int uart_div(int clk_hz, int baud, int os)
//   - localparam UART_DATA_BITS=8
//   - shared with the future turtle_uart_tx.
// - Sub-module uart_baud_tick (DIV counter, restart input, tick output).
//   Reused by the TX side; everything else inline.
// TESTING (bench uses CLK_FREQ_HZ=1_600_000, BAUD_RATE=100_000 -> DIV=1, 16 clk/bit)
// - Drive 0x55 framed 8N1, rx_ready=1 -> rx_valid 1 cycle, rx_data=0x55, no error pulses.
// - Send 0xA3 then 0x0F, rx_ready=0 -> rx_data stays 0xA3, overrun_err pulses once at 2nd stop.
//   Then rx_ready=1 -> rx_valid drops next cycle.
// - Send 0x3C with stop bit 0, line held low 3 bit times -> frame_err single pulse, rx_valid=0.
//   No new frame until line high; following 0x81 received correctly.
// - 4-clk low glitch on idle line -> returns IDLE at mid-start sample.
//   rx_valid=0, no error pulse, busy drops.
// - Assert reset_n=0 for 1 clk during bit 4 of 0xFF -> all outputs 0.
//   Subsequent 0x12 received cleanly, rx_data=0x12.
// - 16 back-to-back frames 0x00..0x0F, rx_ready=1, baud offset +/-3% -> all bytes in order, no errors.

Source files
------------

// File: rtl/turtle_uart_pkg.sv
// Shared UART definitions for the turtle RX (and future TX) blocks.
package turtle_uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } uart_rx_state_t;

   // Rounded clocks per oversample tick.
   function automatic int uart_div(int clk_hz, int baud, int os);
      return (clk_hz + (baud * os) / 2) / (baud * os);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable.
module uart_baud_tick #(
   parameter int unsigned DIV = 1
) (
   input  logic clk_in,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (restart || cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/turtle_uart_rx.sv
// 8N1 UART receiver: synchronises and oversamples RsRx, reassembles bytes and
// hands them over through a one-entry valid/ready holding register.
module turtle_uart_rx
   import turtle_uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 62_500_000,
   parameter int unsigned BAUD_RATE   = 115_200,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned DATA_BITS   = UART_DATA_BITS
) (
   input  logic                 clk_in,
   input  logic                 reset_n,
   input  logic                 rx_serial,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int unsigned DIV  = uart_div(int'(CLK_FREQ_HZ), int'(BAUD_RATE), int'(OVERSAMPLE));
   localparam int unsigned OS_W = $clog2(OVERSAMPLE);
   localparam int unsigned BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

   if (DIV < 1) begin : g_div_check
      $error("turtle_uart_rx: clock too slow for BAUD_RATE*OVERSAMPLE");
   end
   if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_check
      $error("turtle_uart_rx: OVERSAMPLE must be even and >= 8");
   end

   uart_rx_state_t       state_q, state_d;
   logic [1:0]           sync_q, sync_d;
   logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
   logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 deliver_q, deliver_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 busy_q, busy_d;
   logic                 rx_s;
   logic                 tick;
   logic                 restart;

   assign rx_s = sync_q[1];

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud_tick (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      state_d     = state_q;
      sync_d      = {sync_q[0], rx_serial};
      os_cnt_d    = os_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      deliver_d   = 1'b0;
      frame_err_d = 1'b0;
      restart     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d  = START;
               os_cnt_d = '0;
               restart  = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               if (os_cnt_q == OS_HALF) begin
                  os_cnt_d  = '0;
                  bit_cnt_d = '0;
                  // A start bit that is high again at mid-bit was only a glitch.
                  state_d   = rx_s ? IDLE : DATA;
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (os_cnt_q == OS_LAST) begin
                  os_cnt_d  = '0;
                  shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == BC_LAST) begin
                     state_d = STOP;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (os_cnt_q == OS_LAST) begin
                  os_cnt_d = '0;
                  if (rx_s) begin
                     deliver_d = 1'b1;
                     state_d   = IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = WAIT_HIGH;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end
         WAIT_HIGH: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // Holding register; deliver_q only fires while idle, so it never meets frame_err.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = 1'b0;
      if (deliver_q) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         sync_q      <= 2'b11;
         os_cnt_q    <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         deliver_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         os_cnt_q    <= os_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         deliver_q   <= deliver_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_q;
   assign busy        = busy_q;

endmodule
